// File: rtl/add_accum_pkg.sv
// Shared definitions for the add_accum frame accumulator: state encodings,
// default widths and a helper for sizing the sample counter.
package add_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_ACC_W = 8;

    // Counter must reach COUNT itself, so it needs one bit beyond clog2.
    function automatic int cnt_width(input int count);
        return $clog2(count) + 1;
    endfunction

endpackage

// File: rtl/add_sat.sv
// Combinational ACC_W-bit adder with carry-out detection; optionally clamps
// the result to all-ones when the carry-out is set.
module add_sat
    import add_accum_pkg::*;
#(
    parameter int ACC_W    = DEF_ACC_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] wide;

    // Widened sum; bit ACC_W is the overflow indication.
    always_comb begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = wide[ACC_W];
        if (wide[ACC_W] && SATURATE) begin
            sum_o = '1;
        end else begin
            sum_o = wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/add_accum.sv
// Frame accumulator: sums exactly COUNT unsigned samples per frame and holds
// the total plus a sticky overflow flag until the consumer takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no partial frame; next accepted sample starts a new frame
// ST_ACCUM | frame partially accumulated, waiting for more samples
// ST_HOLD  | frame complete; result presented until out_ready
module add_accum
    import add_accum_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int COUNT    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  in_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    assign in_ext = ACC_W'(in_data);

    add_sat #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_add_sat (
        .a_i   (acc_q),
        .b_i   (in_ext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; clear aborts everything and accepts nothing.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_d   = in_ext;
                        cnt_d   = CW'(1);
                        ovf_d   = 1'b0;
                        state_d = (COUNT == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CW'(1);
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q != ST_HOLD);
        out_valid = (state_q == ST_HOLD);
        busy      = (state_q == ST_ACCUM);
        out_sum   = out_valid ? acc_q : '0;
        out_ovf   = out_valid & ovf_q;
    end

endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: three instances (8-bit saturating, 5-bit saturating,
// 5-bit wrapping) share one input stream; a frame-level model predicts results.
module tb_add_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       rdy_a, rdy_b, rdy_c;
    logic       ov_a, ov_b, ov_c;
    logic       bz_a, bz_b, bz_c;
    logic       of_a, of_b, of_c;
    logic [7:0] sum_a;
    logic [4:0] sum_b, sum_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: samples accepted in the current frame and whether a result is held.
    int frame[$];
    bit m_hold = 1'b0;

    always #5 clk = ~clk;

    add_accum #(.IN_W(4), .ACC_W(8), .COUNT(4), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_ovf(of_a), .busy(bz_a));

    add_accum #(.IN_W(4), .ACC_W(5), .COUNT(4), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_ovf(of_b), .busy(bz_b));

    add_accum #(.IN_W(4), .ACC_W(5), .COUNT(4), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
        .out_sum(sum_c), .out_ovf(of_c), .busy(bz_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int raw_total();
        int t = 0;
        foreach (frame[i]) t += frame[i];
        return t;
    endfunction

    function automatic int exp_sum(input int w, input bit sat);
        int mx = (1 << w) - 1;
        int t  = raw_total();
        if (sat) return (t > mx) ? mx : t;
        return t % (1 << w);
    endfunction

    function automatic int exp_ovf(input int w);
        return (raw_total() > ((1 << w) - 1)) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        int ebusy = (!m_hold && frame.size() > 0) ? 1 : 0;
        chk({tag, ".in_ready"},  {29'd0, rdy_a, rdy_b, rdy_c}, m_hold ? 0 : 7);
        chk({tag, ".out_valid"}, {29'd0, ov_a, ov_b, ov_c},    m_hold ? 7 : 0);
        chk({tag, ".busy"},      {29'd0, bz_a, bz_b, bz_c},    ebusy ? 7 : 0);
        if (m_hold) begin
            chk({tag, ".sum8sat"}, 32'(sum_a), exp_sum(8, 1'b1));
            chk({tag, ".sum5sat"}, 32'(sum_b), exp_sum(5, 1'b1));
            chk({tag, ".sum5wrap"}, 32'(sum_c), exp_sum(5, 1'b0));
            chk({tag, ".ovf8"}, 32'(of_a), exp_ovf(8));
            chk({tag, ".ovf5sat"}, 32'(of_b), exp_ovf(5));
            chk({tag, ".ovf5wrap"}, 32'(of_c), exp_ovf(5));
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check after it.
    task automatic step(input string tag, input bit v, input logic [3:0] d,
                        input bit ordy, input bit clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        if (clr) begin
            frame.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (ordy) begin
                frame.delete();
                m_hold = 1'b0;
            end
        end else if (v) begin
            frame.push_back(int'(d));
            if (frame.size() == 4) m_hold = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [3:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'($urandom), 1'b0, 1'b0);
    endtask

    task automatic take(input string tag);
        step(tag, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    // Assert reset between edges and check outputs before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        frame.delete();
        m_hold = 1'b0;
        #1;
        check_all(tag);
        chk({tag, ".sum_zero"}, {8'd0, sum_a, 3'd0, sum_b, 3'd0, sum_c}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check_all("reset");
        chk("reset.sum_ovf", {8'd0, sum_a, sum_b, sum_c, 3'd0, of_a, of_b, of_c}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("post_reset");

        // Back-to-back frame, then backpressure in HOLD
        send("b2b0", 4'd3); send("b2b1", 4'd5); send("b2b2", 4'd7); send("b2b3", 4'd15);
        for (int i = 0; i < 5; i++) step("hold_stable", 1'b0, 4'd0, 1'b0, 1'b0);
        take("b2b_take");

        // Overflow frame, then a clean frame
        for (int i = 0; i < 4; i++) send("ovf", 4'd15);
        take("ovf_take");
        for (int i = 0; i < 4; i++) send("after_ovf", 4'd1);
        take("after_ovf_take");

        // Gapped input
        send("gap0", 4'd1);
        for (int i = 0; i < 3; i++) idle("gap_idle");
        send("gap1", 4'd2); send("gap2", 4'd3); send("gap3", 4'd4);
        take("gap_take");

        // Abort with a sample in the same cycle, then full frame
        send("abort0", 4'd9); send("abort1", 4'd9);
        step("abort_clr", 1'b1, 4'd5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send("post_abort", 4'd1);
        // HOLD ignores in_valid; data 7 lands after handoff
        send("hold_ign0", 4'd7); send("hold_ign1", 4'd7);
        step("hold_handoff", 1'b1, 4'd7, 1'b1, 1'b0);
        send("next_first", 4'd7);
        send("next1", 4'd1); send("next2", 4'd1); send("next3", 4'd1);
        take("next_take");

        // Clear while holding a result
        for (int i = 0; i < 4; i++) send("pre_clr_hold", 4'd6);
        step("clr_in_hold", 1'b0, 4'd0, 1'b0, 1'b1);

        // Async reset mid-ACCUM and in HOLD
        send("rst_acc0", 4'd4); send("rst_acc1", 4'd4);
        async_reset("arst_accum");
        for (int i = 0; i < 4; i++) send("rst_hold", 4'd8);
        async_reset("arst_hold");
        for (int i = 0; i < 4; i++) send("post_rst", 4'd2);
        take("post_rst_take");

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom % 4) != 0, 4'($urandom), 1'($urandom),
                 ($urandom % 20) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
